// File: rtl/alsu_pkg.sv
// Shared types for the ALSU arbiter: command packing,
// opcodes and controller state encoding.
package alsu_pkg;

    localparam int CMD_W = 16;

    localparam int CIN_BIT    = 15;
    localparam int SERIAL_BIT = 14;
    localparam int RED_A_BIT  = 13;
    localparam int RED_B_BIT  = 12;
    localparam int BYP_A_BIT  = 11;
    localparam int BYP_B_BIT  = 10;
    localparam int DIR_BIT    = 9;
    localparam int OP_LSB     = 6;
    localparam int A_LSB      = 3;
    localparam int B_LSB      = 0;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    typedef logic [CMD_W-1:0] cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alsu_arbiter_if.sv
// Requester, ALSU and response signals of the ALSU arbiter.
// slave is the arbiter side, master the requester/ALSU side.
interface alsu_arbiter_if;
    import alsu_pkg::*;

    logic       req0;
    cmd_t       cmd0;
    logic       req1;
    cmd_t       cmd1;
    logic       gnt0;
    logic       gnt1;
    cmd_t       alsu_cmd;
    logic [5:0] alsu_out;
    logic       alsu_invalid;
    logic       rsp_valid;
    logic       rsp_id;
    logic [5:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    modport slave (
        input  req0, cmd0, req1, cmd1, alsu_out, alsu_invalid,
        output gnt0, gnt1, alsu_cmd,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0, cmd0, req1, cmd1, alsu_out, alsu_invalid,
        input  gnt0, gnt1, alsu_cmd,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/alsu_rr_picker.sv
// Combinational two-way picker: round-robin on ties,
// or strict requester-0 priority in FIXED mode.
module alsu_rr_picker #(
    parameter string ARB_MODE = "RR"
) (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic valid,
    output logic winner
);
    localparam bit FIXED = (ARB_MODE == "FIXED");

    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        unique case (1'b1)
            req0 && req1:  winner = FIXED ? 1'b0 : ~last_served;
            req1 && !req0: winner = 1'b1;
            default:       winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one ALSU between two requesters: grants one command,
// applies it for a single ALSU edge, returns the tagged result.
module alsu_arbiter
    import alsu_pkg::*;
#(
    parameter int    ALSU_LATENCY = 2,
    parameter string ARB_MODE     = "RR",
    parameter cmd_t  NOP_CMD      = 16'h0000
) (
    input logic           clk,
    input logic           rst,
    alsu_arbiter_if.slave bus
);
    localparam int            CW       = $clog2(ALSU_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(ALSU_LATENCY - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          last_served;
    logic          id;
    logic          pick_valid;
    logic          winner;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic          rsp_err_q;
    logic          busy_q;
    logic [5:0]    rsp_data_q;
    cmd_t          alsu_cmd_q;

    alsu_rr_picker #(.ARB_MODE(ARB_MODE)) picker (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_served (last_served),
        .valid       (pick_valid),
        .winner      (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (pick_valid) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (cnt == '0) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs; requests seen outside IDLE never reach the datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            last_served <= 1'b1;
            id          <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            alsu_cmd_q  <= NOP_CMD;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            busy_q <= (state_n != IDLE);
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        alsu_cmd_q  <= winner ? bus.cmd1 : bus.cmd0;
                        gnt0_q      <= ~winner;
                        gnt1_q      <= winner;
                        id          <= winner;
                        last_served <= winner;
                    end
                end
                ISSUE: begin
                    gnt0_q     <= 1'b0;
                    gnt1_q     <= 1'b0;
                    alsu_cmd_q <= NOP_CMD;
                    cnt        <= CNT_INIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_data_q  <= bus.alsu_out;
                        rsp_err_q   <= bus.alsu_invalid;
                        rsp_id_q    <= id;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.alsu_cmd  = alsu_cmd_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Scoreboard bench for alsu_arbiter: transaction-level model feeds
// expected grants/responses, a negedge monitor checks the DUT.
module tb_alsu_arbiter;
    import alsu_pkg::*;

    localparam int   L     = 2;
    localparam cmd_t NOP   = 16'h0000;
    localparam cmd_t FCMD0 = 16'h0091;
    localparam cmd_t FCMD1 = 16'h00D2;

    typedef struct {
        int   cyc;
        logic id;
        cmd_t cmd;
    } gexp_t;

    typedef struct {
        int         cyc;
        logic       id;
        logic [5:0] data;
        logic       err;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alsu_arbiter_if bus ();
    alsu_arbiter_if fbus ();

    alsu_arbiter #(
        .ALSU_LATENCY (L),
        .ARB_MODE     ("RR"),
        .NOP_CMD      (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alsu_arbiter #(
        .ALSU_LATENCY (L),
        .ARB_MODE     ("FIXED"),
        .NOP_CMD      (NOP)
    ) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (fbus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    gexp_t gq[$];
    rexp_t rq[$];
    int    glog[$];
    int    gcyc[$];
    int    rlog[$];
    int    rsp_cnt  = 0;
    int    f_last   = -1;
    int    f_cnt    = 0;
    int    f_g1     = 0;

    function automatic logic [6:0] alsu_fn(input cmd_t c);
        int a;
        int b;
        int ci;
        a  = int'(c[A_LSB +: 3]);
        b  = int'(c[B_LSB +: 3]);
        ci = int'(c[CIN_BIT]);
        case (c[OP_LSB +: 3])
            OP_AND:     return {1'b0, 6'(a & b)};
            OP_XOR:     return {1'b0, 6'(a ^ b)};
            OP_ADD:     return {1'b0, 6'(a + b + ci)};
            OP_MULT:    return {1'b0, 6'(a * b)};
            3'd6, 3'd7: return 7'b100_0000;
            default:    return 7'd0;
        endcase
    endfunction

    function automatic cmd_t mk(input logic [2:0] op, input logic [2:0] a,
                                input logic [2:0] b, input logic cin);
        cmd_t c;
        c = '0;
        c[CIN_BIT]     = cin;
        c[OP_LSB +: 3] = op;
        c[A_LSB +: 3]  = a;
        c[B_LSB +: 3]  = b;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        int   k;
        c = 16'($urandom);
        k = int'($urandom_range(0, 5));
        c[OP_LSB +: 3] = 3'((k < 4) ? k : k + 2);
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stub ALSU: registered inputs, registered result
    cmd_t       stub_cmd;
    logic [6:0] stub_res;
    always @(posedge clk) begin
        stub_cmd <= bus.alsu_cmd;
        stub_res <= alsu_fn(stub_cmd);
    end
    assign bus.alsu_out     = stub_res[5:0];
    assign bus.alsu_invalid = stub_res[6];

    assign fbus.req0         = 1'b1;
    assign fbus.req1         = 1'b1;
    assign fbus.cmd0         = FCMD0;
    assign fbus.cmd1         = FCMD1;
    assign fbus.alsu_out     = '0;
    assign fbus.alsu_invalid = 1'b0;

    // Reference model: one transaction per L+3 edges, response L+1 after grant
    int         free_at  = 0;
    int         last_dec = -100;
    logic       m_last   = 1'b1;
    logic       m_w;
    cmd_t       m_c;
    logic [6:0] m_r;
    gexp_t      m_g;
    rexp_t      m_rs;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst) begin
            gq.delete();
            rq.delete();
            m_last   = 1'b1;
            free_at  = 0;
            last_dec = -100;
        end else if (cyc >= free_at && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) m_w = ~m_last;
            else                      m_w = bus.req1;
            m_c       = m_w ? bus.cmd1 : bus.cmd0;
            m_r       = alsu_fn(m_c);
            m_g.cyc   = cyc;
            m_g.id    = m_w;
            m_g.cmd   = m_c;
            gq.push_back(m_g);
            m_rs.cyc  = cyc + L + 1;
            m_rs.id   = m_w;
            m_rs.data = m_r[5:0];
            m_rs.err  = m_r[6];
            rq.push_back(m_rs);
            m_last    = m_w;
            free_at   = cyc + L + 3;
            last_dec  = cyc;
        end
    end

    gexp_t mon_g;
    rexp_t mon_r;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            f_last = -1;
        end else begin
            if (bus.gnt0 || bus.gnt1) begin
                glog.push_back(int'(bus.gnt1));
                gcyc.push_back(cyc);
                chk("gnt_onehot", int'(bus.gnt0 & bus.gnt1), 0);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 1, 0);
                end else begin
                    mon_g = gq.pop_front();
                    chk("gnt_cycle", cyc, mon_g.cyc);
                    chk("gnt_id", int'(bus.gnt1), int'(mon_g.id));
                    chk("alsu_cmd_issue", int'(bus.alsu_cmd), int'(mon_g.cmd));
                end
            end else begin
                chk("alsu_cmd_nop", int'(bus.alsu_cmd), int'(NOP));
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                rlog.push_back(int'(bus.rsp_data));
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    mon_r = rq.pop_front();
                    chk("rsp_cycle", cyc, mon_r.cyc);
                    chk("rsp_id", int'(bus.rsp_id), int'(mon_r.id));
                    chk("rsp_data", int'(bus.rsp_data), int'(mon_r.data));
                    chk("rsp_err", int'(bus.rsp_err), int'(mon_r.err));
                end
            end else if (rq.size() != 0 && cyc > rq[0].cyc) begin
                chk("rsp_missing", cyc, rq[0].cyc);
                rq.delete(0);
            end
            chk("busy", int'(bus.busy),
                int'(cyc >= last_dec && cyc <= last_dec + L + 1));
            if (fbus.gnt1) begin
                f_g1++;
                chk("fixed_gnt1", 1, 0);
            end
            if (fbus.gnt0) begin
                f_cnt++;
                chk("fixed_cmd", int'(fbus.alsu_cmd), int'(FCMD0));
                if (f_last >= 0) chk("fixed_period", cyc - f_last, L + 3);
                f_last = cyc;
            end
        end
    end

    task automatic run(input int n, input int hold_pct, input int raise_pct,
                       input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.gnt0) begin
                if (int'($urandom_range(0, 99)) < hold_pct) begin
                    if (rnd) bus.cmd0 = rnd_cmd();
                end else begin
                    bus.req0 = 1'b0;
                end
            end
            if (bus.gnt1) begin
                if (int'($urandom_range(0, 99)) < hold_pct) begin
                    if (rnd) bus.cmd1 = rnd_cmd();
                end else begin
                    bus.req1 = 1'b0;
                end
            end
            if (rnd && !bus.req0 && int'($urandom_range(0, 99)) < raise_pct) begin
                bus.cmd0 = rnd_cmd();
                bus.req0 = 1'b1;
            end
            if (rnd && !bus.req1 && int'($urandom_range(0, 99)) < raise_pct) begin
                bus.cmd1 = rnd_cmd();
                bus.req1 = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt0"}, int'(bus.gnt0), 0);
        chk({tag, "_gnt1"}, int'(bus.gnt1), 0);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
        chk({tag, "_rsp_data"}, int'(bus.rsp_data), 0);
        chk({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_alsu_cmd"}, int'(bus.alsu_cmd), int'(NOP));
    endtask

    task automatic clear_logs();
        glog.delete();
        gcyc.delete();
        rlog.delete();
    endtask

    int r0;

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = NOP;
        bus.cmd1 = NOP;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // single request: 3 + 2 + 1
        clear_logs();
        bus.cmd0 = mk(OP_ADD, 3'd3, 3'd2, 1'b1);
        bus.req0 = 1'b1;
        run(12, 0, 0, 1'b0);
        chk("single_grants", glog.size(), 1);
        chk("single_data", rlog.size() > 0 ? rlog[0] : -1, 6);
        chk("single_id", int'(bus.rsp_id), 0);
        chk("single_err", int'(bus.rsp_err), 0);

        // round-robin tie from reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        bus.cmd0 = mk(OP_ADD, 3'd1, 3'd1, 1'b0);
        bus.cmd1 = mk(OP_MULT, 3'd7, 3'd7, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        run(11, 100, 0, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        run(8, 0, 0, 1'b0);
        chk("tie_grants", glog.size(), 3);
        chk("tie_first", glog.size() > 0 ? glog[0] : -1, 0);
        chk("tie_second", glog.size() > 1 ? glog[1] : -1, 1);
        chk("tie_third", glog.size() > 2 ? glog[2] : -1, 0);
        chk("tie_rsp1_data", rlog.size() > 1 ? rlog[1] : -1, 49);

        // invalid opcode from requester 1
        r0 = rsp_cnt;
        bus.cmd1 = mk(3'd7, 3'd2, 3'd5, 1'b0);
        bus.req1 = 1'b1;
        run(10, 0, 0, 1'b0);
        chk("inv_err", int'(bus.rsp_err), 1);
        chk("inv_id", int'(bus.rsp_id), 1);
        chk("inv_pulses", rsp_cnt - r0, 1);

        // reset while waiting on the ALSU
        bus.cmd0 = mk(OP_MULT, 3'd3, 3'd3, 1'b0);
        bus.req0 = 1'b1;
        run(2, 0, 0, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        r0 = rsp_cnt;
        rst = 1'b1;
        run(L + 4, 0, 0, 1'b0);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        clear_logs();
        bus.cmd0 = rnd_cmd();
        bus.cmd1 = rnd_cmd();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        run(1, 0, 0, 1'b0);
        chk("abort_tie_first", glog.size() > 0 ? glog[0] : -1, 0);
        run(12, 0, 0, 1'b0);
        chk("abort_tie_grants", glog.size(), 2);

        // changes during WAIT are ignored
        clear_logs();
        bus.cmd0 = mk(OP_ADD, 3'd5, 3'd4, 1'b0);
        bus.req0 = 1'b1;
        run(2, 0, 0, 1'b0);
        bus.cmd0 = mk(OP_MULT, 3'd7, 3'd7, 1'b0);
        bus.cmd1 = mk(OP_ADD, 3'd1, 3'd1, 1'b0);
        bus.req1 = 1'b1;
        run(14, 0, 0, 1'b0);
        chk("busy_first_data", rlog.size() > 0 ? rlog[0] : -1, 9);
        chk("busy_second_id", glog.size() > 1 ? glog[1] : -1, 1);
        chk("busy_second_data", rlog.size() > 1 ? rlog[1] : -1, 2);
        chk("busy_gap", gcyc.size() > 1 ? gcyc[1] - gcyc[0] : -1, L + 3);

        // randomized traffic
        run(600, 50, 30, 1'b1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        run(12, 0, 0, 1'b0);

        chk("gq_drained", gq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("fixed_gnt0_seen", int'(f_cnt > 50), 1);
        chk("fixed_gnt1_total", f_g1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alsu_arbiter.md
Name: alsu_arbiter

Overview:
- Shares one ALSU instance between two requesters (e.g. a UART command port and a switch/button front end).
- Accepts packed ALSU commands from requester 0 and requester 1, arbitrates between them, and issues one command to the ALSU for exactly one cycle.
- Waits out the ALSU pipeline latency, then returns the captured result and error flag tagged with the requester ID.
- Sits between the requesters and the ALSU input/output ports.

Parameters:
- ALSU_LATENCY, 2: clock edges from the ALSU sampling its inputs to its output being valid; legal range 1..7.
- ARB_MODE, "RR": "RR" selects round-robin; "FIXED" gives requester 0 strict priority.
- NOP_CMD, 16'h0000: command driven to the ALSU whenever no command is being issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request.
- cmd0  in  16  requester 0 command {cin,serial_in,red_op_A,red_op_B,bypass_A,bypass_B,direction,opcode[2:0],A[2:0],B[2:0]}.
- req1  in  1  requester 1 request.
- cmd1  in  16  requester 1 command, same packing as cmd0.
- gnt0  out  1  one-cycle accept pulse to requester 0.
- gnt1  out  1  one-cycle accept pulse to requester 1.
- alsu_cmd  out  16  unpacked by the parent onto the ALSU inputs.
- alsu_out  in  6  ALSU result.
- alsu_invalid  in  1  ALSU invalid-operation flag.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  6  captured alsu_out.
- rsp_err  out  1  captured alsu_invalid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt0, gnt1, rsp_valid, rsp_id, rsp_data, rsp_err = 0; alsu_cmd=NOP_CMD; counter=0.
  - last_served=1, so requester 0 wins the first tie.
  - Reset mid-operation aborts the command: no response is ever produced for it.
- All outputs are registered.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, on an edge with req0 or req1 high:
  - Select a winner.
  - RR: a lone request wins; on a tie, the requester other than last_served wins.
  - FIXED: req0 wins whenever it is high.
  - Register alsu_cmd<=winning cmd, gnt_winner<=1, id<=winner, last_served<=winner; state<=ISSUE.
  - With no request, state stays IDLE and alsu_cmd stays NOP_CMD.
- ISSUE (one cycle):
  - The gnt pulse and alsu_cmd are visible this cycle.
  - On the next edge: gnt<=0, alsu_cmd<=NOP_CMD, counter<=ALSU_LATENCY-1, state<=WAIT.
  - The command is therefore applied for exactly one ALSU sampling edge, so shift/rotate ops act once.
- WAIT:
  - Decrement counter each edge.
  - When counter==0, capture rsp_data<=alsu_out, rsp_err<=alsu_invalid, rsp_id<=id, rsp_valid<=1; state<=RESP.
- RESP (one cycle): rsp_valid<=0, state<=IDLE.
  - rsp_data, rsp_id and rsp_err hold until the next capture.
- Timing:
  - rsp_valid rises ALSU_LATENCY+1 edges after the gnt edge.
  - Throughput: one command per ALSU_LATENCY+3 cycles.
  - Earliest next gnt is the edge after RESP.
- Requester handshake:
  - Hold req and cmd stable until gnt is seen.
  - Drop req in the gnt cycle.
  - A req still high in the next IDLE is treated as a new command.
- req/cmd changes outside IDLE are ignored; the latched command is unaffected.
- Counter width is $clog2(ALSU_LATENCY+1). With ALSU_LATENCY=1, WAIT lasts one cycle.

Decomposition:
- Package alsu_pkg:
  - Command field offsets and CMD_W=16.
  - Opcode constants OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MULT=3, OP_SHIFT=4, OP_ROTATE=5; 6 and 7 are invalid.
  - FSM state encoding IDLE/ISSUE/WAIT/RESP.
- One sub-module, alsu_rr_picker: a combinational 2-way picker taking req0, req1, last_served and ARB_MODE, returning valid and winner.

Test Plan:
- Bench uses a stub ALSU with registered inputs and output (ALSU_LATENCY=2) computing ADD = A+B+cin and MULT = A*B; opcodes 6/7 set invalid.
- Single request: req0, cmd0 with opcode=2, A=3, B=2, cin=1 -> gnt0 one cycle; alsu_cmd equals cmd0 for exactly one cycle then 16'h0000; rsp_valid 3 edges after gnt; rsp_id=0, rsp_data=6, rsp_err=0.
- Tie RR:
  - req0 and req1 both held high; cmd1 has opcode=3, A=7, B=7.
  - Expected grant order: gnt0, gnt1, gnt0.
  - Response for requester 1: rsp_id=1, rsp_data=49.
- FIXED mode with req0 and req1 held high -> only gnt0 ever pulses; req1 is never granted while req0 stays high.
- Invalid opcode: cmd1 with opcode=7 -> rsp_err=1, rsp_id=1, rsp_valid a single cycle.
- Reset mid-operation: drop rst while in WAIT -> all outputs 0 immediately and alsu_cmd=NOP_CMD; after release, no rsp_valid for the aborted command; the next tie grants requester 0.
- Ignore-while-busy: change cmd0 and pulse req1 during WAIT -> rsp_data reflects the originally latched command; the new req1 is granted only after RESP.
